pcm_lin_interp: RTL and testbench
=================================

// Module: pcm_lin_interp
// PURPOSE
// - Upstream feeder for the 2nd-order delta-sigma DAC modulator: accepts 16-bit signed PCM at audio
//   rate over a valid/ready handshake and linearly interpolates it to the oversampled clock rate.
// - Presents a new 16-bit signed sample on dout every clk, wired straight to the modulator's din.
// - Removes the zero-order-hold images that the modulator would otherwise pass through.
// PARAMETERS
// - DAC_BW   16  PCM sample width (signed, two's complement)
// - OS_LOG2  10  log2 of clocks per input sample; N = 2**OS_LOG2 (1024 clk/sample at 192 MHz ~ 187.5 kHz)
// PORTS
// - clk        in   1        oversampling clock (the modulator clock)
// - rst        in   1        asynchronous, active-high reset
// - s_data     in   DAC_BW   signed PCM input sample
// - s_valid    in   1        s_data valid
// - s_ready    out  1        block can accept s_data this cycle
// - dout       out  DAC_BW   interpolated signed sample, updated every clk
// - frame_stb  out  1        1-cycle pulse on the cycle phase wraps (N-1 -> 0)
// - underrun   out  1        1-cycle pulse when a frame starts with no buffered sample
// BEHAVIOUR
// - Reset is asynchronous, active-high:
//   - dout=0, frame_stb=0, underrun=0, s_ready=1.
//   - phase=0, acc=0, cur=0, nxt=0, buffer empty, state=PRIME.
// - Storage:
//   - 1-deep input buffer buf/buf_full.
//   - Interpolation endpoints cur and nxt, each DAC_BW bits signed.
//   - phase counter, OS_LOG2 bits, free-running in RUN.
// - Handshake:
//   - Transfer occurs when s_valid && s_ready.
//   - s_ready = !buf_full || consume, where consume is the cycle buf moves into nxt.
//   - A transfer on a consume cycle refills buf in the same edge; there is no bubble.
// - Arithmetic:
//   - delta = nxt - cur, DAC_BW+1 bits signed.
//   - acc is DAC_BW+1+OS_LOG2 bits signed. acc += delta each RUN cycle and clears to 0 at wrap, so acc = phase*delta.
//   - dout (registered) = cur + (acc >>> OS_LOG2). The shift is arithmetic, i.e. floor rounding.
//   - Result always lies between cur and nxt inclusive, so it cannot overflow DAC_BW.
// - State PRIME:
//   - phase and acc are held at 0; dout=0.
//   - On the cycle buf_full is seen: nxt<=buf, buf empties (consume), cur stays 0, -> RUN.
//   - First frame is therefore a ramp from 0 to the first sample (soft start, no step).
// - State RUN:
//   - phase increments every clk.
//   - At wrap (phase==N-1): frame_stb=1, cur<=nxt, acc<=0.
//     - If buf_full: nxt<=buf (consume).
//     - Else: nxt is unchanged (delta becomes 0, output holds) and underrun=1 for 1 cycle. State stays RUN.
// - Latency:
//   - Sample accepted at edge T is in buf at T+1.
//   - In PRIME, nxt is loaded at T+1; dout starts ramping at T+2.
//   - dout reaches that sample exactly at the first wrap after it became nxt.
// - Reset mid-frame: all state is discarded immediately; the block restarts in PRIME with dout=0.
// - s_data is ignored when s_valid=0. Holding s_valid high with buf full is legal: s_ready stays 0 until consume.
// TESTING (OS_LOG2=2, N=4)
// - Reset released, s_valid=0 -> dout=0, s_ready=1, frame_stb=0, underrun=0 indefinitely (PRIME).
// - Soft start:
//   - Stimulus: push 400, then 800 immediately.
//   - Response: dout = 0,100,200,300 then 400,500,600,700.
//   - frame_stb at each wrap; s_ready low while buf holds 800 until consume.
// - Negative floor:
//   - Stimulus: cur=0, nxt=-3.
//   - Response: dout = 0,-1,-2,-3 (arithmetic shift floor); then 32767 -> -32768 full-scale swing.
//   - Response: steps of -16383/-16384 per clk with no wrap-around of dout.
// - Underrun:
//   - Stimulus: push 100 and 200, then stop s_valid.
//   - Response: after the ramp to 200, a 1-cycle underrun pulse; dout holds 200 every cycle of the next frame.
//   - Response: a new sample of 0 then ramps 200,150,100,50.
// - Back-to-back:
//   - Stimulus: s_valid held high with an incrementing counter.
//   - Response: exactly one transfer per N clks after priming, accepted on the consume cycle.
//   - Response: no underrun and no dropped or duplicated sample (scoreboard).
// - Async reset asserted mid-ramp (phase=2, dout=250) -> dout=0 and s_ready=1 before the next clk edge.
// - After that reset: restart from PRIME; the next sample ramps from 0.

Source files
------------

// File: rtl/pcm_lin_interp_if.sv
`default_nettype none
// ============================================================================
// pcm_lin_interp_if : PCM stream input and interpolated output bundle
// Rev 1.0
// ============================================================================
interface pcm_lin_interp_if #(
  parameter int DAC_BW = 16
);
  logic [DAC_BW-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DAC_BW-1:0] dout;
  logic              frame_stb;
  logic              underrun;

  modport master (
    output s_data, s_valid,
    input  s_ready, dout, frame_stb, underrun
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, dout, frame_stb, underrun
  );
endinterface
`default_nettype wire

// File: rtl/pcm_lin_interp.sv
`default_nettype none
// ============================================================================
// pcm_lin_interp : linear interpolator from audio-rate PCM to modulator rate
// Rev 1.0
// ============================================================================
module pcm_lin_interp #(
  parameter int DAC_BW  = 16,
  parameter int OS_LOG2 = 10
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pcm_lin_interp_if.slave bus
);
  localparam int                 ACC_W      = DAC_BW + 1 + OS_LOG2;
  localparam logic [OS_LOG2-1:0] PHASE_LAST = '1;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [OS_LOG2-1:0]       phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DAC_BW-1:0] cur_q, cur_d;
  logic signed [DAC_BW-1:0] nxt_q, nxt_d;
  logic signed [DAC_BW-1:0] buf_q, buf_d;
  logic signed [DAC_BW-1:0] dout_q, dout_d;
  logic                     buf_full_q, buf_full_d;
  logic                     frame_stb_q, frame_stb_d;
  logic                     underrun_q, underrun_d;

  logic signed [DAC_BW:0]   delta;
  logic                     wrap;
  logic                     consume;
  logic                     xfer;

  assign wrap        = (state_q == ST_RUN) && (phase_q == PHASE_LAST);
  assign consume     = buf_full_q && ((state_q == ST_PRIME) || wrap);
  assign bus.s_ready = !buf_full_q || consume;
  assign xfer        = bus.s_valid && bus.s_ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    frame_stb_d = 1'b0;
    underrun_d  = 1'b0;
    delta       = {nxt_q[DAC_BW-1], nxt_q} - {cur_q[DAC_BW-1], cur_q};

    // A consume and a fresh transfer on the same edge leave the buffer full.
    if (xfer) begin
      buf_d      = bus.s_data;
      buf_full_d = 1'b1;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end

    case (state_q)
      ST_PRIME: begin
        phase_d = '0;
        acc_d   = '0;
        if (buf_full_q) begin
          nxt_d   = buf_q;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        phase_d = phase_q + 1'b1;
        if (wrap) begin
          frame_stb_d = 1'b1;
          cur_d       = nxt_q;
          acc_d       = '0;
          if (buf_full_q) begin
            nxt_d = buf_q;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          acc_d = acc_q + {{(ACC_W-DAC_BW-1){delta[DAC_BW]}}, delta};
        end
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase

    // The true result lies between cur and nxt, so the low DAC_BW bits of
    // cur + floor(acc / N) are exact; taking just those bits avoids a wide sum.
    dout_d = cur_d + acc_d[DAC_BW+OS_LOG2-1:OS_LOG2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PRIME;
      phase_q     <= '0;
      acc_q       <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      dout_q      <= '0;
      frame_stb_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      dout_q      <= dout_d;
      frame_stb_q <= frame_stb_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.frame_stb = frame_stb_q;
  assign bus.underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_lin_interp.sv
`default_nettype none
// ============================================================================
// tb_pcm_lin_interp : directed bench for pcm_lin_interp with N = 4
// Rev 1.0
// ============================================================================
module tb_pcm_lin_interp;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_q[$];

  pcm_lin_interp_if #(.DAC_BW(16)) bus_if ();

  pcm_lin_interp #(
    .DAC_BW (16),
    .OS_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic ramp(input string tag);
    foreach (exp_q[i]) begin
      tick();
      chk(tag, $signed(bus_if.dout), exp_q[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int accq[$];
    int cnt;
    int k;
    int nx;
    int udr_seen;
    logic took;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;

    // reset state
    tick();
    tick();
    chk("rst_dout",  $signed(bus_if.dout), 0);
    chk("rst_ready", int'(bus_if.s_ready), 1);
    chk("rst_stb",   int'(bus_if.frame_stb), 0);
    chk("rst_udr",   int'(bus_if.underrun), 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_dout",  $signed(bus_if.dout), 0);
    chk("idle_ready", int'(bus_if.s_ready), 1);
    chk("idle_stb",   int'(bus_if.frame_stb), 0);
    chk("idle_udr",   int'(bus_if.underrun), 0);

    // soft start: 400 then 800
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd400;
    tick();
    chk("ss_ready_prime", int'(bus_if.s_ready), 1);
    bus_if.s_data = 16'd800;
    tick();
    bus_if.s_valid = 1'b0;
    chk("ss_dout0", $signed(bus_if.dout), 0);
    chk("ss_ready_full", int'(bus_if.s_ready), 0);
    exp_q = '{100, 200, 300};
    ramp("ss_ramp1");
    chk("ss_ready_consume", int'(bus_if.s_ready), 1);
    tick();
    chk("ss_wrap1_dout", $signed(bus_if.dout), 400);
    chk("ss_wrap1_stb",  int'(bus_if.frame_stb), 1);
    chk("ss_wrap1_udr",  int'(bus_if.underrun), 0);
    tick();
    chk("ss_dout500", $signed(bus_if.dout), 500);
    chk("ss_stb_low", int'(bus_if.frame_stb), 0);
    exp_q = '{600, 700, 800};
    ramp("ss_ramp2");
    chk("ss_wrap2_udr", int'(bus_if.underrun), 1);

    // negative floor and full-scale swing
    do_reset();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'(-3);
    tick();
    bus_if.s_valid = 1'b0;
    tick();
    chk("neg_dout0", $signed(bus_if.dout), 0);
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'h7fff;
    tick();
    bus_if.s_valid = 1'b0;
    chk("neg_dout1", $signed(bus_if.dout), -1);
    exp_q = '{-2, -3, -3};
    ramp("neg_ramp");
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'h8000;
    tick();
    bus_if.s_valid = 1'b0;
    chk("fs_up1", $signed(bus_if.dout), 8189);
    exp_q = '{16382, 24574, 32767, 16383, -1, -16385, -32768};
    ramp("fs_swing");
    chk("fs_end_udr", int'(bus_if.underrun), 1);

    // underrun: hold through an empty frame, then ramp down to 0
    do_reset();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd100;
    tick();
    bus_if.s_data = 16'd200;
    tick();
    bus_if.s_valid = 1'b0;
    chk("ur_dout0", $signed(bus_if.dout), 0);
    exp_q = '{25, 50, 75, 100, 125, 150, 175, 200};
    ramp("ur_ramp");
    chk("ur_pulse", int'(bus_if.underrun), 1);
    chk("ur_stb",   int'(bus_if.frame_stb), 1);
    tick();
    chk("ur_pulse_end", int'(bus_if.underrun), 0);
    chk("ur_hold1", $signed(bus_if.dout), 200);
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd0;
    tick();
    bus_if.s_valid = 1'b0;
    chk("ur_hold2", $signed(bus_if.dout), 200);
    tick();
    chk("ur_hold3", $signed(bus_if.dout), 200);
    tick();
    chk("ur_wrap_dout", $signed(bus_if.dout), 200);
    chk("ur_wrap_udr",  int'(bus_if.underrun), 0);
    exp_q = '{150, 100, 50, 0};
    ramp("ur_down");

    // back-to-back: s_valid held high with an incrementing counter
    do_reset();
    cnt      = 0;
    k        = 0;
    nx       = 0;
    udr_seen = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd0;
    for (int c = 0; c < 30; c++) begin
      took = bus_if.s_ready;
      tick();
      if (took) begin
        accq.push_back(int'(bus_if.s_data));
        cnt++;
        bus_if.s_data = 16'(cnt);
        nx++;
      end
      if (bus_if.underrun) udr_seen++;
      if (bus_if.frame_stb) begin
        chk("b2b_wrap_dout", $signed(bus_if.dout), (k < accq.size()) ? accq[k] : -99999);
        chk("b2b_xfers", nx, (k == 0) ? 3 : 1);
        k++;
        nx = 0;
      end
    end
    bus_if.s_valid = 1'b0;
    chk("b2b_wraps", k, 7);
    chk("b2b_accepted", accq.size(), 9);
    chk("b2b_no_udr", udr_seen, 0);

    // asynchronous reset mid-ramp
    do_reset();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd500;
    tick();
    bus_if.s_valid = 1'b0;
    tick();
    tick();
    chk("ar_dout125", $signed(bus_if.dout), 125);
    tick();
    chk("ar_dout250", $signed(bus_if.dout), 250);
    #2 rst = 1'b1;
    #1;
    chk("ar_dout_now",  $signed(bus_if.dout), 0);
    chk("ar_ready_now", int'(bus_if.s_ready), 1);
    chk("ar_stb_now",   int'(bus_if.frame_stb), 0);
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("ar_prime_dout",  $signed(bus_if.dout), 0);
    chk("ar_prime_ready", int'(bus_if.s_ready), 1);
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd400;
    tick();
    bus_if.s_valid = 1'b0;
    tick();
    chk("ar_restart0", $signed(bus_if.dout), 0);
    tick();
    chk("ar_restart1", $signed(bus_if.dout), 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
